// File: rtl/ram32_fifo_ctl_if.sv
// ram32_fifo_ctl_if
// Producer/consumer side of the RAM32X1D_1 FIFO controller.
//   WR_EN  write request from the producer
//   DIN    write data
//   FULL   FIFO holds 32 entries
//   RD_EN  read request from the consumer
//   DOUT   registered read data
//   EMPTY  FIFO holds no entries
//   COUNT  occupancy, 0..32
// master: the producer/consumer side. slave: the controller.
interface ram32_fifo_ctl_if #(
  parameter int WIDTH = 8
) ();
  logic             WR_EN;
  logic [WIDTH-1:0] DIN;
  logic             FULL;
  logic             RD_EN;
  logic [WIDTH-1:0] DOUT;
  logic             EMPTY;
  logic [5:0]       COUNT;

  modport master (
    output WR_EN, DIN, RD_EN,
    input  FULL, DOUT, EMPTY, COUNT
  );

  modport slave (
    input  WR_EN, DIN, RD_EN,
    output FULL, DOUT, EMPTY, COUNT
  );
endinterface

// File: rtl/ram32_fifo_ctl.sv
// ram32_fifo_ctl
// Sequences WIDTH RAM32X1D_1 slices (32x1 dual-port, falling-edge write) as a
// 32-deep synchronous FIFO. All controller state moves on the rising edge of
// CLK; the slices complete the write on the falling edge inside the same cycle,
// so a word written at edge k is readable through DPO at edge k+1.
//
// Ports:
//   CLK       single clock (slice WCLK is tied to the same net)
//   RST       synchronous active-high reset, priority over all requests
//   fifo      producer/consumer interface (slave modport)
//   RAM_A     write address to A4..A0 of every slice (held between writes)
//   RAM_D     write data, bit i to slice i
//   RAM_WE    write enable, one cycle high per accepted write
//   RAM_DPRA  read address, driven straight from the read pointer
//   RAM_DPO   DPO outputs of the slices, bit i from slice i
//   OVERFLOW  (RAM32_FIFO_CTL_ERR_EN only) sticky: write requested while full
//   UNDERFLOW (RAM32_FIFO_CTL_ERR_EN only) sticky: read requested while empty
//
// Optional build macro: RAM32_FIFO_CTL_ERR_EN adds the OVERFLOW/UNDERFLOW
// flags. Without it, rejected requests are silently dropped.
module ram32_fifo_ctl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] DOUT_INIT = {WIDTH{1'b0}}
) (
  input  logic                   CLK,
  input  logic                   RST,
  ram32_fifo_ctl_if.slave        fifo,
  output logic [4:0]             RAM_A,
  output logic [WIDTH-1:0]       RAM_D,
  output logic                   RAM_WE,
  output logic [4:0]             RAM_DPRA,
  input  logic [WIDTH-1:0]       RAM_DPO
`ifdef RAM32_FIFO_CTL_ERR_EN
  ,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
`endif
);

  logic [4:0]       wptr_r;
  logic [4:0]       rptr_r;
  logic [5:0]       cnt_r;
  logic [5:0]       cnt_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic [WIDTH-1:0] dout_r;
  logic             ram_we_r;
  logic [4:0]       ram_a_r;
  logic [WIDTH-1:0] ram_d_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Requests are qualified only by registered flags, so nothing from the
  // request inputs reaches FULL/EMPTY/COUNT combinationally.
  assign wr_ok_s = fifo.WR_EN & ~full_r;
  assign rd_ok_s = fifo.RD_EN & ~empty_r;

  // Next occupancy: a simultaneous accepted read and write leaves it unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   cnt_nxt_s = cnt_r + 6'd1;
      2'b01:   cnt_nxt_s = cnt_r - 6'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointers, occupancy and the flags derived from the next occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_r  <= 5'd0;
      rptr_r  <= 5'd0;
      cnt_r   <= 6'd0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      // 5-bit pointers wrap 31 -> 0 naturally
      if (wr_ok_s) begin
        wptr_r <= wptr_r + 5'd1;
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + 5'd1;
      end
      cnt_r   <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == 6'd32);
      empty_r <= (cnt_nxt_s == 6'd0);
    end
  end

  // Write port: address/data captured only for accepted writes, so RAM_A
  // keeps the last written address instead of following a wrapped pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_we_r <= 1'b0;
      ram_a_r  <= 5'd0;
      ram_d_r  <= {WIDTH{1'b0}};
    end else begin
      ram_we_r <= wr_ok_s;
      if (wr_ok_s) begin
        ram_a_r <= wptr_r;
        ram_d_r <= fifo.DIN;
      end
    end
  end

  // Read data register: captures DPO at the read pointer on accepted reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_r <= DOUT_INIT;
    end else if (rd_ok_s) begin
      dout_r <= RAM_DPO;
    end
  end

`ifdef RAM32_FIFO_CTL_ERR_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags; observational only, they never gate the datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (fifo.WR_EN & full_r);
      udf_r <= udf_r | (fifo.RD_EN & empty_r);
    end
  end

  assign OVERFLOW  = ovf_r;
  assign UNDERFLOW = udf_r;
`endif

  assign RAM_WE     = ram_we_r;
  assign RAM_A      = ram_a_r;
  assign RAM_D      = ram_d_r;
  assign RAM_DPRA   = rptr_r;
  assign fifo.FULL  = full_r;
  assign fifo.EMPTY = empty_r;
  assign fifo.COUNT = cnt_r;
  assign fifo.DOUT  = dout_r;

endmodule

// File: tb/tb_ram32_fifo_ctl.sv
// tb_ram32_fifo_ctl
// Self-checking bench for ram32_fifo_ctl with a behavioural bank of
// RAM32X1D_1 slices (falling-edge write, asynchronous DPO read). Expected
// read data comes from a scoreboard queue filled on accepted writes.
module tb_ram32_fifo_ctl;

  localparam int         W      = 8;
  localparam logic [7:0] D_INIT = 8'h5A;

  logic         clk;
  logic         rst;
  logic [4:0]   ram_a;
  logic [W-1:0] ram_d;
  logic         ram_we;
  logic [4:0]   ram_dpra;
  logic [W-1:0] ram_dpo;
`ifdef RAM32_FIFO_CTL_ERR_EN
  logic         overflow;
  logic         underflow;
`endif

  ram32_fifo_ctl_if #(.WIDTH(W)) fifo_bus ();

  ram32_fifo_ctl #(.WIDTH(W), .DOUT_INIT(D_INIT)) dut (
    .CLK      (clk),
    .RST      (rst),
    .fifo     (fifo_bus.slave),
    .RAM_A    (ram_a),
    .RAM_D    (ram_d),
    .RAM_WE   (ram_we),
    .RAM_DPRA (ram_dpra),
    .RAM_DPO  (ram_dpo)
`ifdef RAM32_FIFO_CTL_ERR_EN
    ,
    .OVERFLOW (overflow),
    .UNDERFLOW(underflow)
`endif
  );

  // Behavioural RAM32X1D_1 bank: write on the falling edge, async read.
  logic [W-1:0] mem [32];
  always @(negedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end
  assign ram_dpo = mem[ram_dpra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [W-1:0] sb [$];
  logic [5:0]   m_cnt;
  logic [4:0]   m_wptr;
  logic [4:0]   m_rptr;
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_udf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("count", 64'(fifo_bus.COUNT), 64'(m_cnt));
    check("full",  64'(fifo_bus.FULL),  64'(m_cnt == 6'd32));
    check("empty", 64'(fifo_bus.EMPTY), 64'(m_cnt == 6'd0));
    check("dout",  64'(fifo_bus.DOUT),  64'(m_dout));
`ifdef RAM32_FIFO_CTL_ERR_EN
    check("overflow",  64'(overflow),  64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_udf));
`endif
  endtask

  // One reset cycle with the given requests held; RST must win.
  task automatic do_reset(input logic wr, input logic rd);
    fifo_bus.WR_EN = wr;
    fifo_bus.DIN   = 8'hEE;
    fifo_bus.RD_EN = rd;
    rst            = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    m_cnt  = 6'd0;
    m_wptr = 5'd0;
    m_rptr = 5'd0;
    m_dout = D_INIT;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check("rst_we",   64'(ram_we),   64'd0);
    check("rst_a",    64'(ram_a),    64'd0);
    check("rst_d",    64'(ram_d),    64'd0);
    check("rst_dpra", 64'(ram_dpra), 64'd0);
    check_status();
  endtask

  // One functional cycle: drive requests, advance one edge, compare.
  task automatic step(input logic wr, input logic [W-1:0] din, input logic rd);
    logic wr_ok;
    logic rd_ok;
    rst            = 1'b0;
    fifo_bus.WR_EN = wr;
    fifo_bus.DIN   = din;
    fifo_bus.RD_EN = rd;
    wr_ok = wr && (m_cnt != 6'd32);
    rd_ok = rd && (m_cnt != 6'd0);
    check("dpra", 64'(ram_dpra), 64'(m_rptr));
    @(posedge clk); #1;
    check("ram_we", 64'(ram_we), 64'(wr_ok));
    if (wr_ok) begin
      check("ram_a", 64'(ram_a), 64'(m_wptr));
      check("ram_d", 64'(ram_d), 64'(din));
      m_wptr = m_wptr + 5'd1;
    end
    if (wr && (m_cnt == 6'd32)) m_ovf = 1'b1;
    if (rd && (m_cnt == 6'd0))  m_udf = 1'b1;
    // Pop before pushing so the pop returns the oldest stored word.
    if (rd_ok) begin
      m_dout = sb.pop_front();
      m_rptr = m_rptr + 5'd1;
    end
    if (wr_ok) sb.push_back(din);
    if (wr_ok && !rd_ok) m_cnt = m_cnt + 6'd1;
    else if (rd_ok && !wr_ok) m_cnt = m_cnt - 6'd1;
    check_status();
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    fifo_bus.WR_EN = 1'b0;
    fifo_bus.RD_EN = 1'b0;
    fifo_bus.DIN   = 8'h00;

    // Reset then idle
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Single word
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("single_dout", 64'(fifo_bus.DOUT), 64'hA5);

    // Fill and overflow: 33 writes of 0..32 from a clean state
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b1, i[7:0], 1'b0);
    check("fill_full",  64'(fifo_bus.FULL),  64'd1);
    check("fill_count", 64'(fifo_bus.COUNT), 64'd32);
    check("fill_a_nowrap", 64'(ram_a), 64'd31);

    // Drain in order
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_order", 64'(fifo_bus.DOUT), 64'(i));
    end

    // Interleaved write/read with lag 1 across the address wrap
    step(1'b1, 8'h80, 1'b0);
    for (int i = 1; i < 40; i++) step(1'b1, 8'h80 + i[7:0], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("wrap_last", 64'(fifo_bus.DOUT), 64'h80 + 64'd39);

    // Simultaneous read/write while full: only the read is accepted
    for (int i = 0; i < 32; i++) step(1'b1, 8'hC0 ^ i[7:0], 1'b0);
    step(1'b1, 8'h11, 1'b1);
    check("full_rw_count", 64'(fifo_bus.COUNT), 64'd31);
    for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous read/write while empty: only the write is accepted
    step(1'b1, 8'h77, 1'b1);
    check("empty_rw_count", 64'(fifo_bus.COUNT), 64'd1);
    step(1'b0, 8'h00, 1'b1);
    check("empty_rw_data", 64'(fifo_bus.DOUT), 64'h77);

    // Reset mid-stream with both requests high
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h20 + i[7:0], 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_data", 64'(fifo_bus.DOUT), 64'h3C);
    step(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
